// File: rtl/port_prioritizer.sv
`default_nettype none
// ============================================================================
// Module   : port_prioritizer
// Purpose  : Front end of the triple-ported memory path. Compacts the valid
//            requests of original ports 1..3 into priority slots 1..3
//            (slot 1 = highest priority). Each slot is tagged with the 2-bit
//            original port ID so that port_deprioritizer can route results
//            back. A round-robin pointer gives every port fair access to
//            slot 1. There is one registered output stage with a ready/valid
//            handshake.
//
// Parameters
//   WIDTH            data width per port
//   ROTATE           1 = round-robin priority pointer
//                    0 = fixed scan order 1 > 2 > 3
//
// Ports
//   clk              clock, all state on rising edge
//   rst_n            asynchronous active-low reset
//   portN_data_in    original port N data             (N = 1..3)
//   portN_valid_in   original port N request          (N = 1..3)
//   in_ready         bundle accepted this cycle if any valid_in is high
//   out_ready        downstream consumes the registered bundle
//   portN_data_out   slot N data                      (N = 1..3)
//   portN_valid_out  slot N valid                     (N = 1..3)
//   portN_orig_id    slot N original port ID          (N = 1..3)
//   bundle_valid     OR of all slot valids
//
// ID encoding: 2'b00 invalid, 2'b01 port 1, 2'b10 port 2, 2'b11 port 3.
//
// Revision : 1.0  initial release
// ============================================================================
module port_prioritizer #(
  parameter int WIDTH  = 8,
  parameter bit ROTATE = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] port1_data_in,
  input  logic [WIDTH-1:0] port2_data_in,
  input  logic [WIDTH-1:0] port3_data_in,
  input  logic             port1_valid_in,
  input  logic             port2_valid_in,
  input  logic             port3_valid_in,
  output logic             in_ready,
  input  logic             out_ready,
  output logic [WIDTH-1:0] port1_data_out,
  output logic [WIDTH-1:0] port2_data_out,
  output logic [WIDTH-1:0] port3_data_out,
  output logic             port1_valid_out,
  output logic             port2_valid_out,
  output logic             port3_valid_out,
  output logic [1:0]       port1_orig_id,
  output logic [1:0]       port2_orig_id,
  output logic [1:0]       port3_orig_id,
  output logic             bundle_valid
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int         c_num_ports  = 3;
  localparam logic [1:0] c_id_invalid = 2'b00;
  localparam logic [1:0] c_id_port1   = 2'b01;
  localparam logic [1:0] c_id_port2   = 2'b10;
  localparam logic [1:0] c_id_port3   = 2'b11;

  // Successor in the circular scan order 1 -> 2 -> 3 -> 1. An invalid ID
  // never reaches this function on a live path; it maps to port 1 so the
  // pointer can never leave the legal set.
  function automatic logic [1:0] f_next_id(input logic [1:0] id);
    logic [1:0] nxt;
    case (id)
      c_id_port1: nxt = c_id_port2;
      c_id_port2: nxt = c_id_port3;
      default:    nxt = c_id_port1;
    endcase
    return nxt;
  endfunction

  // --------------------------------------------------------------------------
  // Input views as small arrays indexed by (port ID - 1)
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0]       w_in_data [c_num_ports];
  logic [c_num_ports-1:0] w_in_valid;

  assign w_in_data[0] = port1_data_in;
  assign w_in_data[1] = port2_data_in;
  assign w_in_data[2] = port3_data_in;
  assign w_in_valid   = {port3_valid_in, port2_valid_in, port1_valid_in};

  // --------------------------------------------------------------------------
  // Registered output bundle
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0]       r_slot_data  [c_num_ports];
  logic [c_num_ports-1:0] r_slot_valid;
  logic [1:0]             r_slot_id    [c_num_ports];

  // --------------------------------------------------------------------------
  // Handshake
  // --------------------------------------------------------------------------
  // The output register may be refilled in the same cycle it is consumed,
  // so in_ready follows out_ready combinationally and no bubble is inserted.
  logic w_any_valid;
  logic w_accept;

  assign bundle_valid = |r_slot_valid;
  assign in_ready     = !bundle_valid || out_ready;
  assign w_any_valid  = |w_in_valid;
  assign w_accept     = in_ready && w_any_valid;

  // --------------------------------------------------------------------------
  // Priority pointer: the port ID that is examined first
  // --------------------------------------------------------------------------
  logic [1:0] w_rr_ptr;
  logic [1:0] w_slot_id [c_num_ports];

  generate
    if (ROTATE) begin : g_rr_ptr
      logic [1:0] r_rr_ptr;

      // After each accepted bundle the port that just won slot 1 drops to
      // the back of the scan order. An accepted bundle always has slot 1
      // filled, so w_slot_id[0] is a real port ID here.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_rr_ptr <= c_id_port1;
        end else if (w_accept) begin
          r_rr_ptr <= f_next_id(w_slot_id[0]);
        end
      end

      assign w_rr_ptr = r_rr_ptr;
    end else begin : g_fixed_ptr
      assign w_rr_ptr = c_id_port1;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Scan order: the three port IDs starting at the pointer
  // --------------------------------------------------------------------------
  logic [1:0]             w_scan_id    [c_num_ports];
  logic [WIDTH-1:0]       w_scan_data  [c_num_ports];
  logic [c_num_ports-1:0] w_scan_valid;

  assign w_scan_id[0] = w_rr_ptr;
  assign w_scan_id[1] = f_next_id(w_scan_id[0]);
  assign w_scan_id[2] = f_next_id(w_scan_id[1]);

  always_comb begin
    for (int k = 0; k < c_num_ports; k++) begin
      w_scan_data[k]  = '0;
      w_scan_valid[k] = 1'b0;
      case (w_scan_id[k])
        c_id_port1: begin
          w_scan_data[k]  = w_in_data[0];
          w_scan_valid[k] = w_in_valid[0];
        end
        c_id_port2: begin
          w_scan_data[k]  = w_in_data[1];
          w_scan_valid[k] = w_in_valid[1];
        end
        c_id_port3: begin
          w_scan_data[k]  = w_in_data[2];
          w_scan_valid[k] = w_in_valid[2];
        end
        default: begin
          w_scan_data[k]  = '0;
          w_scan_valid[k] = 1'b0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Compaction: the k-th valid port found in scan order lands in slot k.
  // Unused slots keep data 0, valid 0, ID invalid.
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0]       w_slot_data  [c_num_ports];
  logic [c_num_ports-1:0] w_slot_valid;
  logic [1:0]             w_fill;

  always_comb begin
    for (int s = 0; s < c_num_ports; s++) begin
      w_slot_data[s]  = '0;
      w_slot_valid[s] = 1'b0;
      w_slot_id[s]    = c_id_invalid;
    end
    w_fill = 2'd0;
    for (int k = 0; k < c_num_ports; k++) begin
      if (w_scan_valid[k]) begin
        // w_fill counts slots already used; it is at most 2 when a port is
        // placed because only three ports exist.
        case (w_fill)
          2'd0: begin
            w_slot_data[0]  = w_scan_data[k];
            w_slot_valid[0] = 1'b1;
            w_slot_id[0]    = w_scan_id[k];
          end
          2'd1: begin
            w_slot_data[1]  = w_scan_data[k];
            w_slot_valid[1] = 1'b1;
            w_slot_id[1]    = w_scan_id[k];
          end
          default: begin
            w_slot_data[2]  = w_scan_data[k];
            w_slot_valid[2] = 1'b1;
            w_slot_id[2]    = w_scan_id[k];
          end
        endcase
        w_fill = w_fill + 2'd1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output stage
  // --------------------------------------------------------------------------
  // Load on accept; otherwise a consume (out_ready) returns the stage to its
  // reset values. When the stage is already empty that clear is a no-op, and
  // when out_ready is low the bundle holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < c_num_ports; s++) begin
        r_slot_data[s]  <= '0;
        r_slot_valid[s] <= 1'b0;
        r_slot_id[s]    <= c_id_invalid;
      end
    end else if (w_accept) begin
      for (int s = 0; s < c_num_ports; s++) begin
        r_slot_data[s]  <= w_slot_data[s];
        r_slot_valid[s] <= w_slot_valid[s];
        r_slot_id[s]    <= w_slot_id[s];
      end
    end else if (out_ready) begin
      for (int s = 0; s < c_num_ports; s++) begin
        r_slot_data[s]  <= '0;
        r_slot_valid[s] <= 1'b0;
        r_slot_id[s]    <= c_id_invalid;
      end
    end
  end

  assign port1_data_out  = r_slot_data[0];
  assign port2_data_out  = r_slot_data[1];
  assign port3_data_out  = r_slot_data[2];
  assign port1_valid_out = r_slot_valid[0];
  assign port2_valid_out = r_slot_valid[1];
  assign port3_valid_out = r_slot_valid[2];
  assign port1_orig_id   = r_slot_id[0];
  assign port2_orig_id   = r_slot_id[1];
  assign port3_orig_id   = r_slot_id[2];

  // --------------------------------------------------------------------------
  // Structural invariants of the registered bundle
  // --------------------------------------------------------------------------
  logic [3*WIDTH+3+6-1:0] w_out_flat;

  assign w_out_flat = {r_slot_data[2], r_slot_data[1], r_slot_data[0],
                       r_slot_valid,
                       r_slot_id[2], r_slot_id[1], r_slot_id[0]};

  // Slots fill from slot 1 upward with no gaps.
  a_compact : assert property (@(posedge clk) disable iff (!rst_n)
    (!r_slot_valid[1] || r_slot_valid[0]) && (!r_slot_valid[2] || r_slot_valid[1]));

  // A slot carries a real ID exactly when it is valid; empty slots carry 0 data.
  a_id_valid : assert property (@(posedge clk) disable iff (!rst_n)
    ((r_slot_id[0] != c_id_invalid) == r_slot_valid[0]) &&
    ((r_slot_id[1] != c_id_invalid) == r_slot_valid[1]) &&
    ((r_slot_id[2] != c_id_invalid) == r_slot_valid[2]) &&
    (r_slot_valid[0] || r_slot_data[0] == '0) &&
    (r_slot_valid[1] || r_slot_data[1] == '0) &&
    (r_slot_valid[2] || r_slot_data[2] == '0));

  // Valid slots never share an original port.
  a_distinct : assert property (@(posedge clk) disable iff (!rst_n)
    (!r_slot_valid[1] || r_slot_id[1] != r_slot_id[0]) &&
    (!r_slot_valid[2] || (r_slot_id[2] != r_slot_id[0] && r_slot_id[2] != r_slot_id[1])));

  // A stalled bundle is held unchanged.
  a_hold : assert property (@(posedge clk) disable iff (!rst_n)
    (bundle_valid && !out_ready) |=> $stable(w_out_flat));

endmodule

`default_nettype wire

// File: tb/tb_port_prioritizer.sv
`default_nettype none
// ============================================================================
// Module   : tb_port_prioritizer
// Purpose  : Self-checking bench for port_prioritizer. A rotating instance
//            and a fixed-order instance share the same stimulus. Accepted
//            bundles are predicted by a queue-based reference model and
//            pushed into per-instance scoreboards; a monitor on the falling
//            edge compares the presented bundle against the scoreboard head
//            and retires it when the downstream consumes it.
// Revision : 1.0  initial release
// ============================================================================
module tb_port_prioritizer;

  localparam int WIDTH = 8;

  typedef struct packed {
    logic [2:0][WIDTH-1:0] d;
    logic [2:0]            v;
    logic [2:0][1:0]       id;
  } bundle_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  logic [WIDTH-1:0] p1_d = '0, p2_d = '0, p3_d = '0;
  logic             p1_v = 1'b0, p2_v = 1'b0, p3_v = 1'b0;
  logic             out_ready = 1'b0;

  logic             rot_in_ready, rot_bv;
  logic [WIDTH-1:0] rot_d1, rot_d2, rot_d3;
  logic             rot_v1, rot_v2, rot_v3;
  logic [1:0]       rot_id1, rot_id2, rot_id3;

  logic             fix_in_ready, fix_bv;
  logic [WIDTH-1:0] fix_d1, fix_d2, fix_d3;
  logic             fix_v1, fix_v2, fix_v3;
  logic [1:0]       fix_id1, fix_id2, fix_id3;

  always #5 clk = ~clk;

  port_prioritizer #(.WIDTH(WIDTH), .ROTATE(1'b1)) dut_rot (
    .clk(clk), .rst_n(rst_n),
    .port1_data_in(p1_d), .port2_data_in(p2_d), .port3_data_in(p3_d),
    .port1_valid_in(p1_v), .port2_valid_in(p2_v), .port3_valid_in(p3_v),
    .in_ready(rot_in_ready), .out_ready(out_ready),
    .port1_data_out(rot_d1), .port2_data_out(rot_d2), .port3_data_out(rot_d3),
    .port1_valid_out(rot_v1), .port2_valid_out(rot_v2), .port3_valid_out(rot_v3),
    .port1_orig_id(rot_id1), .port2_orig_id(rot_id2), .port3_orig_id(rot_id3),
    .bundle_valid(rot_bv)
  );

  port_prioritizer #(.WIDTH(WIDTH), .ROTATE(1'b0)) dut_fix (
    .clk(clk), .rst_n(rst_n),
    .port1_data_in(p1_d), .port2_data_in(p2_d), .port3_data_in(p3_d),
    .port1_valid_in(p1_v), .port2_valid_in(p2_v), .port3_valid_in(p3_v),
    .in_ready(fix_in_ready), .out_ready(out_ready),
    .port1_data_out(fix_d1), .port2_data_out(fix_d2), .port3_data_out(fix_d3),
    .port1_valid_out(fix_v1), .port2_valid_out(fix_v2), .port3_valid_out(fix_v3),
    .port1_orig_id(fix_id1), .port2_orig_id(fix_id2), .port3_orig_id(fix_id3),
    .bundle_valid(fix_bv)
  );

  // Scoreboards and model state
  bundle_t q_rot[$];
  bundle_t q_fix[$];
  int      m_ptr_rot = 1;     // port examined first by the rotating model
  bit      m_bv      = 1'b0;  // model: a bundle sits in the output stage
  int      checks    = 0;
  int      failures  = 0;

  // Reference model: list the valid ports in circular order starting at ptr,
  // then deal them out to slots 1, 2, 3. Next pointer follows the slot-1 port.
  function automatic bundle_t model(input logic [2:0] v,
                                    input logic [2:0][WIDTH-1:0] d,
                                    input int ptr, output int next_ptr);
    int      order[$];
    bundle_t b;
    b = '0;
    for (int k = 0; k < 3; k++) begin
      int p;
      p = ((ptr - 1 + k) % 3) + 1;
      if (v[p-1]) order.push_back(p);
    end
    for (int s = 0; s < order.size(); s++) begin
      b.d[s]  = d[order[s]-1];
      b.v[s]  = 1'b1;
      b.id[s] = 2'(order[s]);
    end
    next_ptr = (order.size() > 0) ? (order[0] % 3) + 1 : ptr;
    return b;
  endfunction

  function automatic bundle_t get_rot();
    bundle_t b;
    b.d  = {rot_d3, rot_d2, rot_d1};
    b.v  = {rot_v3, rot_v2, rot_v1};
    b.id = {rot_id3, rot_id2, rot_id1};
    return b;
  endfunction

  function automatic bundle_t get_fix();
    bundle_t b;
    b.d  = {fix_d3, fix_d2, fix_d1};
    b.v  = {fix_v3, fix_v2, fix_v1};
    b.id = {fix_id3, fix_id2, fix_id1};
    return b;
  endfunction

  task automatic check_bundle(input string name, input bundle_t act, input bundle_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s @%0t: got d=%h v=%b id=%h, expected d=%h v=%b id=%h",
               name, $time, act.d, act.v, act.id, exp.d, exp.v, exp.id);
    end
  endtask

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Driver: present inputs, let one rising edge pass, update the model with
  // what that edge does, return 1 time unit after the edge.
  task automatic step(input logic [2:0] v, input logic [2:0][WIDTH-1:0] d, input logic ordy);
    bit acc;
    int np;
    p1_v = v[0]; p2_v = v[1]; p3_v = v[2];
    p1_d = d[0]; p2_d = d[1]; p3_d = d[2];
    out_ready = ordy;
    @(posedge clk);
    if (rst_n) begin
      acc = (!m_bv || ordy) && (v != 3'b000);
      if (acc) begin
        q_rot.push_back(model(v, d, m_ptr_rot, np));
        m_ptr_rot = np;
        q_fix.push_back(model(v, d, 1, np));
        m_bv = 1'b1;
      end else if (ordy) begin
        m_bv = 1'b0;
      end
    end
    #1;
  endtask

  // Monitor: compare the presented bundle with the scoreboard head; retire it
  // when out_ready says the next edge consumes it.
  always @(negedge clk) begin
    check_val("in_ready_rot", 32'(rot_in_ready), 32'(!m_bv || out_ready));
    check_val("in_ready_fix", 32'(fix_in_ready), 32'(!m_bv || out_ready));
    check_val("bundle_valid_rot", 32'(rot_bv), 32'(m_bv));
    if (q_rot.size() > 0) begin
      check_bundle("slots_rot", get_rot(), q_rot[0]);
      if (out_ready && rst_n) void'(q_rot.pop_front());
    end else begin
      check_bundle("idle_rot", get_rot(), '0);
    end
    if (q_fix.size() > 0) begin
      check_bundle("slots_fix", get_fix(), q_fix[0]);
      if (out_ready && rst_n) void'(q_fix.pop_front());
    end else begin
      check_bundle("idle_fix", get_fix(), '0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0][WIDTH-1:0] all3;
    logic [2:0][WIDTH-1:0] rd;
    all3 = {8'h33, 8'h22, 8'h11};

    // Reset
    repeat (2) @(posedge clk);
    #1;
    check_bundle("reset_state", get_rot(), '0);
    check_val("reset_bv", 32'(rot_bv), 32'd0);
    rst_n = 1'b1;
    check_val("in_ready_after_reset", 32'(rot_in_ready), 32'd1);

    // All ports valid, four back-to-back bundles
    step(3'b111, all3, 1'b1);
    check_val("first_s1_id", 32'(rot_id1), 32'h1);
    check_val("first_s1_d",  32'(rot_d1),  32'h11);
    check_val("first_s2_id", 32'(rot_id2), 32'h2);
    check_val("first_s2_d",  32'(rot_d2),  32'h22);
    check_val("first_s3_id", 32'(rot_id3), 32'h3);
    check_val("first_s3_d",  32'(rot_d3),  32'h33);
    step(3'b111, all3, 1'b1);
    check_val("rr_s1_id_2", 32'(rot_id1), 32'h2);
    check_val("rr_bv_2", 32'(rot_bv), 32'd1);
    check_val("fixed_s1_id_2", 32'(fix_id1), 32'h1);
    step(3'b111, all3, 1'b1);
    check_val("rr_s1_id_3", 32'(rot_id1), 32'h3);
    check_val("fixed_s1_id_3", 32'(fix_id1), 32'h1);
    step(3'b111, all3, 1'b1);
    check_val("rr_s1_id_4", 32'(rot_id1), 32'h1);
    check_val("fixed_s1_id_4", 32'(fix_id1), 32'h1);

    // Only port 3 valid
    step(3'b100, {8'hA5, 8'h00, 8'h00}, 1'b1);
    check_val("p3only_s1_id", 32'(rot_id1), 32'h3);
    check_val("p3only_s1_d",  32'(rot_d1),  32'hA5);
    check_val("p3only_s2", 32'({rot_v2, rot_id2, rot_d2}), 32'd0);
    check_val("p3only_s3", 32'({rot_v3, rot_id3, rot_d3}), 32'd0);

    // Pointer now back at port 1
    step(3'b111, all3, 1'b1);
    check_val("after_p3_s1_id", 32'(rot_id1), 32'h1);

    // Hold for four cycles with changing inputs
    for (int i = 0; i < 4; i++) begin
      rd = 24'($urandom);
      step(3'($urandom_range(0, 7)), rd, 1'b0);
      check_val("hold_s1_id", 32'(rot_id1), 32'h1);
      check_val("hold_s1_d",  32'(rot_d1),  32'h11);
      check_val("hold_in_ready", 32'(rot_in_ready), 32'd0);
    end

    // Release: consume and accept on the same edge (pointer at port 2)
    step(3'b011, {8'h00, 8'h55, 8'h44}, 1'b1);
    check_val("release_s1_id", 32'(rot_id1), 32'h2);
    check_val("release_s1_d",  32'(rot_d1),  32'h55);
    check_val("release_s2_id", 32'(rot_id2), 32'h1);
    check_val("release_s3_v",  32'(rot_v3),  32'd0);
    check_val("release_fix_s1_id", 32'(fix_id1), 32'h1);

    // Hold, then reset in the middle of it
    step(3'b111, {8'h66, 8'h77, 8'h88}, 1'b0);
    check_val("prereset_bv", 32'(rot_bv), 32'd1);
    rst_n = 1'b0;
    #1;
    check_bundle("midreset_rot", get_rot(), '0);
    check_bundle("midreset_fix", get_fix(), '0);
    check_val("midreset_bv", 32'(rot_bv), 32'd0);
    q_rot.delete();
    q_fix.delete();
    m_bv      = 1'b0;
    m_ptr_rot = 1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_val("postreset_in_ready", 32'(rot_in_ready), 32'd1);
    step(3'b111, all3, 1'b1);
    check_val("postreset_s1_id", 32'(rot_id1), 32'h1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      rd = 24'($urandom);
      step(3'($urandom_range(0, 7)), rd, ($urandom_range(0, 9) < 7));
    end

    // Drain
    for (int i = 0; i < 3; i++) step(3'b000, '0, 1'b1);
    check_val("drain_bv", 32'(rot_bv), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/port_prioritizer.md
Name: port_prioritizer

Overview:
- Front end of the triple-ported memory path.
- Takes one request bundle from original ports 1..3 and compacts the valid requests into priority slots 1..3, where slot 1 is highest priority.
- Tags each slot with the 2-bit original port ID; the downstream port_deprioritizer uses that tag to route results back.
- Round-robin rotation gives fair slot-1 access; one registered output stage with a ready/valid handshake.

Parameters:
WIDTH, 8, data width per port
ROTATE, 1, 1 = round-robin priority pointer; 0 = fixed order 1>2>3 (pointer held at 1)

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
port1_data_in  input  WIDTH  original port 1 data
port2_data_in  input  WIDTH  original port 2 data
port3_data_in  input  WIDTH  original port 3 data
port1_valid_in  input  1  original port 1 request
port2_valid_in  input  1  original port 2 request
port3_valid_in  input  1  original port 3 request
in_ready  output  1  bundle accepted this cycle if any valid_in high
out_ready  input  1  downstream consumes the registered bundle
port1_data_out  output  WIDTH  slot 1 data
port2_data_out  output  WIDTH  slot 2 data
port3_data_out  output  WIDTH  slot 3 data
port1_valid_out  output  1  slot 1 valid
port2_valid_out  output  1  slot 2 valid
port3_valid_out  output  1  slot 3 valid
port1_orig_id  output  2  slot 1 original port ID
port2_orig_id  output  2  slot 2 original port ID
port3_orig_id  output  2  slot 3 original port ID
bundle_valid  output  1  OR of portN_valid_out

Behaviour:
- ID encoding (shared_params.vh): ORIG_PORT_INVALID_ID=2'b00, ORIG_PORT_1_ID=2'b01, ORIG_PORT_2_ID=2'b10, ORIG_PORT_3_ID=2'b11.
- Reset, asynchronous, while rst_n=0:
  - all data_out=0, valid_out=0, orig_id=INVALID, bundle_valid=0;
  - rr_ptr=1;
  - in_ready=1 once reset is released.
- Readiness and acceptance:
  - in_ready = !bundle_valid | out_ready, combinational, no bubble.
  - Accept = in_ready & (any valid_in). Bundles with no valid input are never accepted and leave state unchanged.
- Compaction order on accept: scan ports rr_ptr, rr_ptr+1, rr_ptr+2, mod 3 with wrap 3->1.
  - The k-th valid port found goes to slot k with its data, valid=1 and ID.
  - Unused slots get data=0, valid=0, ID=INVALID.
  - Output IDs are therefore distinct unless INVALID.
- Latency: exactly 1 cycle from accept edge to registered outputs.
- Hold: if bundle_valid & !out_ready, all outputs hold stable and input is not accepted.
- Consume without new accept (bundle_valid & out_ready & no valid_in): outputs clear to reset values next cycle.
- Back-to-back: consume and accept in the same cycle replaces the bundle with no idle cycle.
- Pointer (ROTATE=1):
  - On accept, rr_ptr becomes the successor of the port placed in slot 1 (1->2, 2->3, 3->1).
  - rr_ptr holds otherwise.
  - With ROTATE=0, rr_ptr stays 1.
- Inputs are sampled only when accepted; the upstream holds valid/data until in_ready, and the block does not check this.
- Reset mid-bundle drops the held bundle and clears outputs immediately.
- Round trip: feeding slot outputs and IDs into port_deprioritizer must reproduce the original data/valid per port.

Test Plan:
- Reset, then ports 1/2/3 valid with data 0x11/0x22/0x33, out_ready=1 -> next cycle:
  - slots give (ID 01, 0x11), (ID 10, 0x22), (ID 11, 0x33);
  - rr_ptr=2.
- Repeat the same all-valid bundle for 3 more cycles -> slot 1 IDs sequence 10, 11, 01; no idle cycle between bundles.
- Only port 3 valid (0xA5), rr_ptr=1 -> next cycle:
  - slot 1 = (ID 11, 0xA5), slots 2/3 valid=0, ID=00, data 0;
  - rr_ptr=1 (successor of 3).
- Bundle held with out_ready=0 for 4 cycles while inputs change -> outputs stable, in_ready=0. Then out_ready=1 -> new bundle appears the following cycle.
- ROTATE=0, all ports valid for 3 cycles -> slot 1 ID always 01.
- rst_n asserted mid-hold while bundle_valid=1 -> all outputs 0 and IDs 00 immediately. After release, rr_ptr=1 and in_ready=1.
